// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for bus_arbiter5: FSM state, requester count,
// mux5 select codes and the round-robin winner pick.
package bus_arb_pkg;

  typedef enum logic {IDLE, GRANT} state_e;

  localparam int NUM_REQ = 5;

  localparam logic [2:0] SEL_IN1 = 3'b000;
  localparam logic [2:0] SEL_IN2 = 3'b001;
  localparam logic [2:0] SEL_IN3 = 3'b010;
  localparam logic [2:0] SEL_IN4 = 3'b011;
  localparam logic [2:0] SEL_IN5 = 3'b100;

  // First set bit of req scanning upward from ptr, wrapping 4 -> 0.
  // Returns SEL_IN1 when nothing is requesting; callers test |req themselves.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [2:0]         ptr);
    logic       found;
    logic [2:0] idx;
    rr_pick = SEL_IN1;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = 3'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

  function automatic logic [2:0] rr_next(input logic [2:0] k);
    return (k == SEL_IN5) ? SEL_IN1 : k + 3'd1;
  endfunction

endpackage

// File: rtl/mux5.sv
// Combinational 5:1 word mux for the shared operand/result bus.
module mux5
  import bus_arb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = '0;
    case (s)
      SEL_IN1: out = in1;
      SEL_IN2: out = in2;
      SEL_IN3: out = in3;
      SEL_IN4: out = in4;
      SEL_IN5: out = in5;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter5.sv
// Round-robin arbiter for the 5:1 bus: grants one requester at a time, drives mux5
// and registers the selected word. Define BUS_ARB_TIMEOUT_EN to bound locked ownership.
module bus_arbiter5
  import bus_arb_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [WIDTH-1:0]   in3,
  input  logic [WIDTH-1:0]   in4,
  input  logic [WIDTH-1:0]   in5,
  output logic [2:0]         sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WIDTH-1:0]   bus_out,
  output logic               bus_valid,
  output logic               timeout
);

  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("bus_arbiter5: MAX_HOLD must be at least 1");
  end

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0]   bus_out_q;
  logic               bus_valid_q;
  logic [WIDTH-1:0]   mux_out;
  logic [2:0]         owner;
  logic [2:0]         pick_k;
  logic [NUM_REQ-1:0] lock_eff;
  logic [NUM_REQ-1:0] pending;
  logic               stay;
  logic               force_rel;

  // While granted, sel_q always names the owner.
  assign owner = sel_q;
  assign stay  = (state_q == GRANT) && req[owner] && lock_eff[owner];

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0] lock_ign_q, lock_ign_d;
  logic               timeout_q;

  // A requester that was force-released has its lock ignored for its next grant.
  assign lock_eff  = lock & ~lock_ign_q;
  assign force_rel = stay && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign timeout   = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
      lock_ign_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      lock_ign_q <= lock_ign_d;
      timeout_q  <= force_rel;
    end
  end
`else
  assign lock_eff  = lock;
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    pending = req & ~(5'b00001 << owner);
    pick_k  = rr_pick(req, ptr_q);
`ifdef BUS_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    lock_ign_d = lock_ign_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = 5'b00001 << pick_k;
          sel_d   = pick_k;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (stay && !force_rel) begin
`ifdef BUS_ARB_TIMEOUT_EN
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
        end else begin
          // Release: the next winner is taken on this same edge, never the old owner.
          ptr_d  = rr_next(owner);
          pick_k = rr_pick(pending, ptr_d);
`ifdef BUS_ARB_TIMEOUT_EN
          hold_cnt_d = '0;
          lock_ign_d = force_rel ? (5'b00001 << owner)
                                 : (lock_ign_q & ~(5'b00001 << owner));
`endif
          if (|pending) begin
            gnt_d = 5'b00001 << pick_k;
            sel_d = pick_k;
          end else begin
            gnt_d   = '0;
            sel_d   = SEL_IN1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= SEL_IN1;
      sel_q       <= SEL_IN1;
      gnt_q       <= '0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      bus_out_q   <= mux_out;
      bus_valid_q <= (state_q == GRANT) && req[owner];
    end
  end

  mux5 #(.WIDTH(WIDTH)) u_mux5 (
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .in4 (in4),
    .in5 (in5),
    .s   (sel_q),
    .out (mux_out)
  );

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;

endmodule
